// File: rtl/conv_ctrl.sv
// Sequencer for a direct 2-D convolution: walks taps and output pixels,
// issuing memory addresses and MAC / bias / save / write strobes.
module conv_ctrl #(
  parameter int IN_W  = 5,
  parameter int IN_H  = 5,
  parameter int IN_C  = 1,
  parameter int K     = 3,
  parameter int OUT_C = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_ctrl,
  output logic [15:0] s_addr,
  output logic [15:0] w_addr,
  output logic [15:0] b_addr,
  output logic [15:0] save_addr,
  output logic        en_sum,
  output logic        en_save,
  output logic        en_read,
  output logic        en_write,
  output logic        en_mac,
  output logic        finish
);
  localparam int OUT_W = IN_W - K + 1;
  localparam int OUT_H = IN_H - K + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAC   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_SUM   = 3'd3;
  localparam logic [2:0] S_SAVE  = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [15:0] K_L  = 16'(K - 1);
  localparam logic [15:0] IC_L = 16'(IN_C - 1);
  localparam logic [15:0] OX_L = 16'(OUT_W - 1);
  localparam logic [15:0] OY_L = 16'(OUT_H - 1);
  localparam logic [15:0] OC_L = 16'(OUT_C - 1);

  typedef struct packed {
    logic [15:0] kx, ky, ic, ox, oy, oc;
  } pos_t;

  logic [2:0]  state, nstate;
  pos_t        pos, npos;
  logic        tap_last, pix_last;
  logic [31:0] s_calc, w_calc, sv_calc;

  assign tap_last = (pos.kx == K_L) && (pos.ky == K_L) && (pos.ic == IC_L);
  assign pix_last = (pos.ox == OX_L) && (pos.oy == OY_L) && (pos.oc == OC_L);

  always_comb begin
    nstate = state;
    npos   = pos;
    case (state)
      S_IDLE: if (en_ctrl) begin
        nstate = S_MAC;
        npos   = '0;
      end
      S_MAC: begin
        if (tap_last) nstate = S_DRAIN;
        else if (pos.kx != K_L) npos.kx = pos.kx + 16'd1;
        else begin
          npos.kx = '0;
          if (pos.ky != K_L) npos.ky = pos.ky + 16'd1;
          else begin
            npos.ky = '0;
            npos.ic = pos.ic + 16'd1;
          end
        end
      end
      S_DRAIN: nstate = S_SUM;
      S_SUM:   nstate = S_SAVE;
      S_SAVE:  nstate = S_WRITE;
      S_WRITE: begin
        if (pix_last) nstate = S_DONE;
        else begin
          nstate  = S_MAC;
          npos.kx = '0;
          npos.ky = '0;
          npos.ic = '0;
          if (pos.ox != OX_L) npos.ox = pos.ox + 16'd1;
          else begin
            npos.ox = '0;
            if (pos.oy != OY_L) npos.oy = pos.oy + 16'd1;
            else begin
              npos.oy = '0;
              npos.oc = pos.oc + 16'd1;
            end
          end
        end
      end
      S_DONE:  if (!en_ctrl) nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Addresses come from the next-cycle counters so they line up with the registered strobes.
  always_comb begin
    s_calc  = (32'(npos.ic) * 32'(IN_H) + 32'(npos.oy) + 32'(npos.ky)) * 32'(IN_W)
              + 32'(npos.ox) + 32'(npos.kx);
    w_calc  = ((32'(npos.oc) * 32'(IN_C) + 32'(npos.ic)) * 32'(K) + 32'(npos.ky)) * 32'(K)
              + 32'(npos.kx);
    sv_calc = (32'(npos.oc) * 32'(OUT_H) + 32'(npos.oy)) * 32'(OUT_W) + 32'(npos.ox);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pos       <= '0;
      s_addr    <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      save_addr <= '0;
      en_read   <= 1'b0;
      en_mac    <= 1'b0;
      en_sum    <= 1'b0;
      en_save   <= 1'b0;
      en_write  <= 1'b0;
      finish    <= 1'b0;
    end else begin
      state    <= nstate;
      pos      <= npos;
      en_read  <= (nstate == S_MAC);
      en_mac   <= en_read;
      en_sum   <= (nstate == S_SUM);
      en_save  <= (nstate == S_SAVE);
      en_write <= (nstate == S_WRITE);
      finish   <= (nstate == S_DONE);
      if (nstate == S_IDLE) begin
        s_addr    <= '0;
        w_addr    <= '0;
        b_addr    <= '0;
        save_addr <= '0;
      end else begin
        if (nstate == S_MAC) begin
          s_addr <= s_calc[15:0];
          w_addr <= w_calc[15:0];
        end
        if (nstate == S_SUM)   b_addr    <= npos.oc;
        if (nstate == S_WRITE) save_addr <= sv_calc[15:0];
      end
    end
  end
endmodule

// File: tb/tb_conv_ctrl.sv
// Cycle-accurate check of conv_ctrl against a loop-nest model of the layer
// walk, with randomized en_ctrl wiggle, idle gaps and a mid-run reset.
module tb_conv_ctrl;
  localparam int IN_W = 5, IN_H = 5, IN_C = 1, K = 3, OUT_C = 2;
  localparam int OUT_W = IN_W - K + 1, OUT_H = IN_H - K + 1;
  localparam int N = IN_C * K * K, PIX = OUT_W * OUT_H * OUT_C;

  logic        clk = 1'b0;
  logic        reset, en_ctrl;
  logic [15:0] s_addr, w_addr, b_addr, save_addr;
  logic        en_sum, en_save, en_read, en_write, en_mac, finish;

  always #5 clk = ~clk;

  conv_ctrl #(.IN_W(IN_W), .IN_H(IN_H), .IN_C(IN_C), .K(K), .OUT_C(OUT_C)) dut (
    .clk(clk), .reset(reset), .en_ctrl(en_ctrl),
    .s_addr(s_addr), .w_addr(w_addr), .b_addr(b_addr), .save_addr(save_addr),
    .en_sum(en_sum), .en_save(en_save), .en_read(en_read), .en_write(en_write),
    .en_mac(en_mac), .finish(finish)
  );

  typedef struct packed {
    logic [15:0] s, w, b, sv;
    logic rd, mac, sum, save, wr, fin;
  } obs_t;

  obs_t cur;
  assign cur = {s_addr, w_addr, b_addr, save_addr, en_read, en_mac, en_sum, en_save, en_write, finish};

  obs_t exp_q[$];
  logic prev_rd;
  int   errors = 0, checks = 0;
  int   s_tab[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // en_mac is simply the read strobe one cycle late.
  function automatic void push(obs_t e);
    e.mac   = prev_rd;
    prev_rd = e.rd;
    exp_q.push_back(e);
  endfunction

  task automatic build_model();
    obs_t e;
    exp_q.delete();
    prev_rd = 1'b0;
    e = '0;
    for (int oc = 0; oc < OUT_C; oc++)
      for (int oy = 0; oy < OUT_H; oy++)
        for (int ox = 0; ox < OUT_W; ox++) begin
          for (int ic = 0; ic < IN_C; ic++)
            for (int ky = 0; ky < K; ky++)
              for (int kx = 0; kx < K; kx++) begin
                e.rd = 1'b1;
                e.s  = 16'((ic * IN_H + oy + ky) * IN_W + ox + kx);
                e.w  = 16'(((oc * IN_C + ic) * K + ky) * K + kx);
                push(e);
              end
          e.rd = 1'b0;
          push(e);
          e.sum = 1'b1; e.b = 16'(oc);
          push(e);
          e.sum = 1'b0; e.save = 1'b1;
          push(e);
          e.save = 1'b0; e.wr = 1'b1; e.sv = 16'((oc * OUT_H + oy) * OUT_W + ox);
          push(e);
          e.wr = 1'b0;
        end
    e.fin = 1'b1;
    push(e);
  endtask

  task automatic run_full(input bit wiggle);
    int fin_at = -1, n_rd = 0, n_mac = 0, n_sum = 0, n_save = 0, n_wr = 0, rd_i = 0, hold;
    logic [15:0] last_sv = '0;
    en_ctrl = 1'b1;
    step();
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("cyc%0d", i), 80'(cur), 80'(exp_q[i]));
      if (finish && fin_at < 0) fin_at = i;
      n_rd += int'(en_read); n_mac += int'(en_mac); n_sum += int'(en_sum);
      n_save += int'(en_save); n_wr += int'(en_write);
      if (en_read && rd_i < N) begin
        check($sformatf("px0_s%0d", rd_i), 80'(s_addr), 80'(s_tab[rd_i]));
        check($sformatf("px0_w%0d", rd_i), 80'(w_addr), 80'(rd_i));
        rd_i++;
      end
      if (en_write) last_sv = save_addr;
      en_ctrl = (wiggle && i < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    hold = $urandom_range(0, 4);
    for (int i = 0; i < hold; i++) begin
      check("done_hold", 80'(cur), 80'(exp_q[exp_q.size() - 1]));
      step();
    end
    en_ctrl = 1'b0;
    step();
    check("idle_after_done", 80'(cur), 80'(0));
    check("finish_cycle", 80'(fin_at), 80'(PIX * (N + 4)));
    check("n_read", 80'(n_rd), 80'(N * PIX));
    check("n_mac", 80'(n_mac), 80'(N * PIX));
    check("n_sum", 80'(n_sum), 80'(PIX));
    check("n_save", 80'(n_save), 80'(PIX));
    check("n_write", 80'(n_wr), 80'(PIX));
    check("last_save_addr", 80'(last_sv), 80'(PIX - 1));
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_gap", 80'(cur), 80'(0));
    end
  endtask

  task automatic reset_mid();
    int stop_at = 4 * (N + 4) + $urandom_range(0, N + 3);
    en_ctrl = 1'b1;
    step();
    for (int i = 0; i <= stop_at; i++) begin
      check($sformatf("pre_rst%0d", i), 80'(cur), 80'(exp_q[i]));
      en_ctrl = 1'($urandom_range(0, 1));
      if (i < stop_at) step();
    end
    reset = 1'b1;
    step();
    check("rst_mid_zero", 80'(cur), 80'(0));
    reset = 1'b0;
    en_ctrl = 1'b0;
    step();
    check("idle_after_rst", 80'(cur), 80'(0));
  endtask

  initial begin
    reset = 1'b1;
    en_ctrl = 1'b0;
    build_model();
    step();
    check("rst_c1", 80'(cur), 80'(0));
    step();
    check("rst_c2", 80'(cur), 80'(0));
    reset = 1'b0;
    idle_gap(10);
    run_full(1'b0);
    idle_gap($urandom_range(1, 5));
    run_full(1'b1);
    reset_mid();
    idle_gap($urandom_range(1, 5));
    run_full(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
